// File: rtl/serv_rf_dbg_pkg.sv
// Shared definitions for the debug-side RF port: FSM state encoding and fixed widths.
package serv_rf_dbg_pkg;

  localparam int DATA_W = 32;
  localparam int NUM_GPR = 32;
  localparam int X0_IDX = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/serv_rf_dbg_port.sv
// Turns parallel debug read/write commands into one bit-serial RF RAM transaction
// and hands back a parallel response; used while the core is halted.
module serv_rf_dbg_port
  import serv_rf_dbg_pkg::*;
#(
  parameter int csr_regs = 4,
  parameter int rw = $clog2(32 + csr_regs),
  parameter int timeout = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  // Command/response handshakes: a beat transfers on the rising edge where
  // valid and ready are both high; valid and its payload are held until then.
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_we,
  input  logic [rw-1:0]     i_cmd_reg,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_busy,
  output logic              o_rreq,
  output logic              o_wreq,
  input  logic              i_ready,
  output logic [rw-1:0]     o_rreg0,
  output logic [rw-1:0]     o_rreg1,
  input  logic              i_rdata0,
  input  logic              i_rdata1,
  output logic [rw-1:0]     o_wreg0,
  output logic              o_wen0,
  output logic              o_wdata0,
  output logic [rw-1:0]     o_wreg1,
  output logic              o_wen1,
  output logic              o_wdata1,
  output state_t            o_dbg_state
);

  localparam logic [rw:0] NUM_REGS = (rw + 1)'(NUM_GPR + csr_regs);
  localparam logic [7:0]  TMO_LAST = 8'(timeout - 1);

  state_t              state;
  state_t              state_nxt;
  logic [4:0]          cnt;
  logic [7:0]          tmo;
  logic [DATA_W-1:0]   sh;
  logic                we_q;
  logic                err_q;
  logic [rw-1:0]       reg_q;
  logic                bad_idx;
  logic                x0_target;
  logic                unused_ok;

  assign bad_idx   = {1'b0, i_cmd_reg} >= NUM_REGS;
  assign x0_target = (reg_q == rw'(X0_IDX));
  assign unused_ok = i_rdata1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    o_cmd_ready = 1'b0;
    o_busy      = 1'b1;
    o_rreq      = 1'b0;
    o_wreq      = 1'b0;
    o_wen0      = 1'b0;
    o_wdata0    = 1'b0;
    o_rsp_valid = 1'b0;
    o_rsp_err   = 1'b0;
    o_rsp_rdata = '0;
    case (state)
      ST_IDLE: begin
        o_busy      = 1'b0;
        o_cmd_ready = !i_rst;
        if (i_cmd_valid) begin
          state_nxt = bad_idx ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        o_rreq    = !we_q;
        o_wreq    = we_q;
        state_nxt = i_ready ? ST_SHIFT : ST_WAIT;
      end
      ST_WAIT: begin
        if (i_ready) begin
          state_nxt = ST_SHIFT;
        end else if (tmo == TMO_LAST) begin
          state_nxt = ST_RESP;
        end
      end
      ST_SHIFT: begin
        // x0 is hardwired zero, so a write to it never enables the RAM.
        o_wen0   = we_q && !x0_target;
        o_wdata0 = we_q && sh[0];
        if (cnt == 5'd31) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        o_rsp_valid = 1'b1;
        o_rsp_err   = err_q;
        o_rsp_rdata = (!we_q && !err_q) ? sh : '0;
        if (i_rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath; the index and payload registers deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= 5'd0;
      tmo <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            we_q  <= i_cmd_we;
            reg_q <= i_cmd_reg;
            sh    <= i_cmd_wdata;
            err_q <= bad_idx;
            cnt   <= 5'd0;
            tmo   <= 8'd0;
          end
        end
        ST_WAIT: begin
          tmo <= tmo + 8'd1;
          if (!i_ready && tmo == TMO_LAST) begin
            err_q <= 1'b1;
          end
        end
        ST_SHIFT: begin
          cnt <= cnt + 5'd1;
          sh  <= {(!we_q && i_rdata0), sh[DATA_W-1:1]};
        end
        default: begin
        end
      endcase
    end
  end

  assign o_rreg0     = reg_q;
  assign o_rreg1     = reg_q;
  assign o_wreg0     = reg_q;
  assign o_wreg1     = '0;
  assign o_wen1      = 1'b0;
  assign o_wdata1    = 1'b0;
  assign o_dbg_state = state;

endmodule

// File: tb/tb_serv_rf_dbg_port.sv
// Bench for serv_rf_dbg_port: bench-side serial RF RAM, register-file reference
// model with expected-read queue, directed scenarios plus randomized commands.
module tb_serv_rf_dbg_port;
  import serv_rf_dbg_pkg::*;

  localparam int NREGS   = 36;
  localparam int TIMEOUT = 15;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        cmd_valid, cmd_ready, cmd_we;
  logic [5:0]  cmd_reg;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        busy, rreq, wreq, ready, rdata0, rdata1;
  logic [5:0]  rreg0, rreg1, wreg0, wreg1;
  logic        wen0, wdata0, wen1, wdata1;
  state_t      dbg_state;

  serv_rf_dbg_port #(.csr_regs(4), .timeout(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_we(cmd_we),
    .i_cmd_reg(cmd_reg), .i_cmd_wdata(cmd_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
    .o_rsp_err(rsp_err), .o_busy(busy), .o_rreq(rreq), .o_wreq(wreq),
    .i_ready(ready), .o_rreg0(rreg0), .o_rreg1(rreg1), .i_rdata0(rdata0),
    .i_rdata1(rdata1), .o_wreg0(wreg0), .o_wen0(wen0), .o_wdata0(wdata0),
    .o_wreg1(wreg1), .o_wen1(wen1), .o_wdata1(wdata1), .o_dbg_state(dbg_state)
  );

  // environment RAM and reference model
  logic [31:0] rf_mem   [0:63];
  logic [31:0] ref_regs [0:NREGS-1];
  logic [31:0] exp_q[$];

  int checks = 0;
  int failures = 0;

  // results of the last transaction
  logic        r_got, r_err;
  logic [31:0] r_rdata;
  int          r_t0, r_req, r_rsp, r_hs, r_nreq, r_nwen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one command from a negedge and play the RF side until the response is
  // taken (or a mid-transaction reset fires at serial bit rst_bit).
  task automatic run_txn(input logic we, input int r, input logic [31:0] wd,
                         input int gdelay, input int hold, input int rst_bit,
                         input int pend);
    int  req_c, grant_c, k, hold_cnt, c;
    bit  done;
    req_c = -1; grant_c = -1; hold_cnt = 0; done = 0; c = 0;
    r_got = 0; r_err = 0; r_rdata = '0; r_req = -1; r_rsp = -1; r_hs = -1;
    r_nreq = 0; r_nwen = 0;
    cmd_valid = 1; cmd_we = we; cmd_reg = 6'(r); cmd_wdata = wd;
    for (int i = 0; i < 60 && !cmd_ready; i++) @(negedge clk);
    check("cmd_accept", cmd_ready, 1);
    r_t0 = cyc;
    @(negedge clk);
    cmd_valid = 0;
    while (!done && c < 100) begin
      if (rst) begin
        check("wen0_after_rst", wen0, 0);
        check("rsp_valid_after_rst", rsp_valid, 0);
        check("busy_after_rst", busy, 0);
        check("cmd_ready_in_rst", cmd_ready, 0);
        rst = 0;
        done = 1;
      end else begin
        ready = 0;
        rdata0 = 0;
        if (wen0) r_nwen++;
        if (rreq || wreq) begin
          r_nreq++; req_c = cyc; r_req = cyc - r_t0;
          check("rreq_dir", rreq, !we);
          check("rreg0_idx", rreg0, r);
          check("rreg1_idx", rreg1, r);
          check("wreg0_idx", wreg0, r);
        end
        if (req_c >= 0 && grant_c < 0 && cyc == req_c + gdelay) begin
          ready = 1; grant_c = cyc;
        end
        if (grant_c >= 0 && cyc > grant_c && cyc <= grant_c + 32) begin
          k = cyc - grant_c - 1;
          rdata0 = rf_mem[rreg0][k];
          if (wen0) rf_mem[wreg0][k] = wdata0;
          if (k == rst_bit) rst = 1;
        end
        if (r_got) begin
          check("rsp_valid_hold", rsp_valid, 1);
          check("rsp_rdata_hold", rsp_rdata, r_rdata);
          check("rsp_err_hold", rsp_err, r_err);
          if (pend >= 0) check("cmd_ready_in_resp", cmd_ready, 0);
          if (hold_cnt >= hold) begin rsp_ready = 1; r_hs = cyc; done = 1; end
          hold_cnt++;
        end else if (rsp_valid) begin
          r_got = 1; r_rsp = cyc - r_t0; r_rdata = rsp_rdata; r_err = rsp_err;
          if (pend >= 0) begin
            cmd_valid = 1; cmd_we = 0; cmd_reg = 6'(pend); cmd_wdata = '0;
            check("cmd_ready_in_resp", cmd_ready, 0);
          end
          if (hold == 0) begin rsp_ready = 1; r_hs = cyc; done = 1; end
          hold_cnt = 1;
        end
      end
      c++;
      if (!done) @(negedge clk);
    end
    checks++;
    assert (done) else begin
      failures++;
      $error("FAIL txn_bound: observed=not_finished expected=finished");
    end
    @(negedge clk);
    rsp_ready = 0; ready = 0; rdata0 = 0;
    check("busy_after_txn", busy, 0);
  endtask

  // Expected outcome from the register-file rules; updates the model on writes.
  task automatic expect_txn(input string tag, input logic we, input int r,
                            input logic [31:0] wd, input int gdelay);
    bit bad, tmo, ok;
    bad = (r >= NREGS);
    tmo = !bad && (gdelay > TIMEOUT);
    ok  = !bad && !tmo;
    exp_q.push_back((ok && !we) ? ref_regs[r] : 32'd0);
    check({tag, "_got"}, r_got, 1);
    check({tag, "_rdata"}, r_rdata, exp_q.pop_front());
    check({tag, "_err"}, r_err, !ok);
    check({tag, "_lat"}, r_rsp, bad ? 1 : (tmo ? TIMEOUT + 2 : gdelay + 34));
    check({tag, "_nreq"}, r_nreq, bad ? 0 : 1);
    check({tag, "_nwen"}, r_nwen, (ok && we && r != 0) ? 32 : 0);
    if (ok && we && r != 0) ref_regs[r] = wd;
  endtask

  initial begin
    int hs, r, g, h;
    logic we;
    logic [31:0] wd;
    rst = 1; cmd_valid = 0; cmd_we = 0; cmd_reg = '0; cmd_wdata = '0;
    rsp_ready = 0; ready = 0; rdata0 = 0; rdata1 = 0;
    for (int i = 0; i < 64; i++) rf_mem[i] = (i == 0) ? 32'd0 : $urandom;
    for (int i = 0; i < NREGS; i++) ref_regs[i] = rf_mem[i];

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp", {rsp_err, rsp_rdata[30:0]}, 0);
    check("rst_rf_ctl", {rreq, wreq, wen0, wdata0, wen1, wdata1}, 0);
    check("rst_wreg1", wreg1, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 0;
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1);

    run_txn(1, 5, 32'hDEADBEEF, 0, 0, -1, -1);
    expect_txn("wr_x5", 1, 5, 32'hDEADBEEF, 0);
    check("wr_x5_req_lat", r_req, 1);
    run_txn(0, 5, '0, 2, 0, -1, -1);
    expect_txn("rd_x5", 0, 5, '0, 2);
    check("rd_x5_value", r_rdata, 32'hDEADBEEF);

    run_txn(1, 0, 32'hFFFFFFFF, 0, 0, -1, -1);
    expect_txn("wr_x0", 1, 0, 32'hFFFFFFFF, 0);
    run_txn(0, 0, '0, 1, 0, -1, -1);
    expect_txn("rd_x0", 0, 0, '0, 1);

    run_txn(0, 40, '0, 0, 0, -1, -1);
    expect_txn("rd_bad40", 0, 40, '0, 0);

    run_txn(0, 3, '0, 1000, 0, -1, -1);
    expect_txn("rd_timeout", 0, 3, '0, 1000);

    run_txn(1, 7, 32'hA5A5A5A5, 0, 0, 10, -1);
    check("rst_mid_no_rsp", r_got, 0);
    for (int i = 0; i < 4; i++) begin
      check("rst_mid_quiet", {rsp_valid, wen0, busy}, 0);
      @(negedge clk);
    end
    ref_regs[7] = (ref_regs[7] & ~32'h7FF) | (32'hA5A5A5A5 & 32'h7FF);
    run_txn(0, 7, '0, 0, 0, -1, -1);
    expect_txn("rd_x7_partial", 0, 7, '0, 0);

    run_txn(0, 5, '0, 0, 5, -1, 9);
    expect_txn("rd_hold", 0, 5, '0, 0);
    hs = r_hs;
    run_txn(0, 9, '0, 0, 0, -1, -1);
    check("pend_accept_gap", r_t0 - hs, 1);
    expect_txn("rd_pend_x9", 0, 9, '0, 0);

    for (int n = 0; n < 14; n++) begin
      we = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 39);
      wd = $urandom;
      g  = $urandom_range(0, 5);
      h  = $urandom_range(0, 2);
      run_txn(we, r, wd, g, h, -1, -1);
      expect_txn(we ? "rnd_wr" : "rnd_rd", we, r, wd, g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
